// File: rtl/capa_transaccion_param.sv
// Parametrised transaction layer: one input FIFO feeds N_CH output FIFOs, steered by
// the top DEST_W bits of each word, with threshold flags and delivered/overflow counters.
module capa_transaccion_param #(
  parameter  int DATA_W = 12,
  parameter  int N_CH   = 4,
  parameter  int DEPTH  = 8,
  parameter  int STAT_W = 8,
  localparam int DEST_W = $clog2(N_CH),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      FIFO_in,
  input  logic                   PUSH,
  input  logic                   Enable,
  input  logic [N_CH-1:0]        pop,
  input  logic [CNT_W-1:0]       umbral_bajo,
  input  logic [CNT_W-1:0]       umbral_alto,
  input  logic                   init,
  input  logic                   req,
  input  logic [DEST_W:0]        idx,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [N_CH-1:0]        valid_out,
  output logic                   almost_full_in,
  output logic [N_CH-1:0]        almost_empty,
  output logic [N_CH-1:0]        almost_full,
  output logic                   error,
  output logic                   idle,
  output logic [STAT_W-1:0]      salida_contador,
  output logic                   valid_contador
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bajo_q, alto_q;

  logic [DATA_W-1:0]   in_mem [DEPTH];
  logic [PTR_W-1:0]    in_wr_q, in_rd_q;
  logic [CNT_W-1:0]    in_cnt_q;

  logic [DATA_W-1:0]   out_mem  [N_CH][DEPTH];
  logic [PTR_W-1:0]    out_wr_q [N_CH];
  logic [PTR_W-1:0]    out_rd_q [N_CH];
  logic [CNT_W-1:0]    out_cnt_q [N_CH];

  logic [STAT_W-1:0]   deliv_q [N_CH];
  logic [STAT_W-1:0]   ovf_q;

  logic [DATA_W-1:0]   head;
  logic [DEST_W-1:0]   dest;
  logic                routing_state, push_ok, push_ref, route, any_data, live;
  logic [N_CH-1:0]     out_thr_full, pop_ok, route_to;

  assign head = in_mem[in_rd_q];
  assign dest = head[DATA_W-1 -: DEST_W];

  // NOTE: every signal driven from always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    routing_state = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    push_ok       = PUSH && (in_cnt_q < CNT_W'(DEPTH));
    push_ref      = PUSH && !push_ok;
    any_data      = (in_cnt_q != '0);
    out_thr_full  = '0;
    pop_ok        = '0;
    route_to      = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_thr_full[k] = (out_cnt_q[k] >= alto_q);
      pop_ok[k]       = pop[k] && (out_cnt_q[k] != '0);
      any_data        = any_data || (out_cnt_q[k] != '0);
    end
    // Head-of-line: a blocked head stalls the whole input FIFO.
    route = routing_state && Enable && (in_cnt_q != '0) && !out_thr_full[dest];
    for (int k = 0; k < N_CH; k++) begin
      route_to[k] = route && (dest == DEST_W'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_INIT;
      S_INIT:   if (!init) state_d = S_IDLE;
      S_IDLE:   if (init) state_d = S_INIT;
                else if (any_data) state_d = S_ACTIVE;
      S_ACTIVE: if (init) state_d = S_INIT;
                else if (!any_data) state_d = S_IDLE;
      default:  state_d = S_RESET;
    endcase
  end

  // Flags are masked only while the FSM sits in RESET; afterwards they follow counts.
  always_comb begin
    live           = (state_q != S_RESET);
    idle           = (state_q == S_IDLE);
    almost_full_in = live && (in_cnt_q >= alto_q);
    almost_empty   = '0;
    almost_full    = '0;
    for (int k = 0; k < N_CH; k++) begin
      almost_empty[k] = live && (out_cnt_q[k] <= bajo_q);
      almost_full[k]  = live && out_thr_full[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      bajo_q  <= '0;
      alto_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        bajo_q <= umbral_bajo;
        alto_q <= umbral_alto;
      end
    end
  end

  // NOTE: storage arrays carry no reset; emptiness is defined by the pointers and
  // counts, so clearing the data itself would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push_ok) in_mem[in_wr_q] <= FIFO_in;
    for (int k = 0; k < N_CH; k++) begin
      if (route_to[k]) out_mem[k][out_wr_q[k]] <= head;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      in_cnt_q <= '0;
      error    <= 1'b0;
    end else begin
      if (push_ok) in_wr_q <= in_wr_q + PTR_W'(1);
      if (route)   in_rd_q <= in_rd_q + PTR_W'(1);
      in_cnt_q <= in_cnt_q + CNT_W'(push_ok) - CNT_W'(route);
      if (push_ref) error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= '0;
      for (int k = 0; k < N_CH; k++) begin
        out_wr_q[k]  <= '0;
        out_rd_q[k]  <= '0;
        out_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (route_to[k]) out_wr_q[k] <= out_wr_q[k] + PTR_W'(1);
        if (pop_ok[k]) begin
          out_rd_q[k]                   <= out_rd_q[k] + PTR_W'(1);
          data_out[k*DATA_W +: DATA_W]  <= out_mem[k][out_rd_q[k]];
        end
        valid_out[k] <= pop_ok[k];
        out_cnt_q[k] <= out_cnt_q[k] + CNT_W'(route_to[k]) - CNT_W'(pop_ok[k]);
      end
    end
  end

  // Reads sample the counters before this edge's increment lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q           <= '0;
      valid_contador  <= 1'b0;
      salida_contador <= '0;
      for (int k = 0; k < N_CH; k++) deliv_q[k] <= '0;
    end else begin
      valid_contador <= 1'b0;
      if (req && (state_q != S_RESET)) begin
        valid_contador  <= 1'b1;
        salida_contador <= (idx < (DEST_W+1)'(N_CH)) ? deliv_q[idx[DEST_W-1:0]] : ovf_q;
      end
      if (state_q == S_INIT) begin
        ovf_q <= '0;
        for (int k = 0; k < N_CH; k++) deliv_q[k] <= '0;
      end else begin
        if (push_ref) ovf_q <= ovf_q + STAT_W'(1);
        for (int k = 0; k < N_CH; k++) begin
          if (pop_ok[k]) deliv_q[k] <= deliv_q[k] + STAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_capa_transaccion_param.sv
// Self-checking bench for capa_transaccion_param: directed table, corner sequences and
// a randomized run against a queue-based reference model.
module tb_capa_transaccion_param;

  localparam int DATA_W = 12;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 8;
  localparam int STAT_W = 8;
  localparam int DEST_W = 2;
  localparam int CNT_W  = 4;

  logic                   clk, reset, PUSH, Enable, init, req;
  logic [DATA_W-1:0]      FIFO_in;
  logic [N_CH-1:0]        pop;
  logic [CNT_W-1:0]       umbral_bajo, umbral_alto;
  logic [DEST_W:0]        idx;
  logic [N_CH*DATA_W-1:0] data_out;
  logic [N_CH-1:0]        valid_out, almost_empty, almost_full;
  logic                   almost_full_in, error, idle, valid_contador;
  logic [STAT_W-1:0]      salida_contador;

  int n_checks = 0;
  int n_errors = 0;

  capa_transaccion_param #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clk(clk), .reset(reset), .FIFO_in(FIFO_in), .PUSH(PUSH), .Enable(Enable), .pop(pop),
    .umbral_bajo(umbral_bajo), .umbral_alto(umbral_alto), .init(init), .req(req), .idx(idx),
    .data_out(data_out), .valid_out(valid_out), .almost_full_in(almost_full_in),
    .almost_empty(almost_empty), .almost_full(almost_full), .error(error), .idle(idle),
    .salida_contador(salida_contador), .valid_contador(valid_contador)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ps, input logic [DATA_W-1:0] d, input logic [N_CH-1:0] p,
                       input logic rq, input logic [DEST_W:0] ix);
    PUSH = ps; FIFO_in = d; pop = p; req = rq; idx = ix;
  endtask

  function automatic logic [DATA_W-1:0] ch(input int k);
    return data_out[k*DATA_W +: DATA_W];
  endfunction

  // ---------------- reference model (queues) ----------------
  logic [DATA_W-1:0] m_in [$];
  logic [DATA_W-1:0] m_out [N_CH][$];
  logic [STAT_W-1:0] m_deliv [N_CH];
  logic [DATA_W-1:0] m_data [N_CH];
  logic [STAT_W-1:0] m_ovf, m_sal;
  logic [N_CH-1:0]   m_valid;
  logic              m_err, m_active, m_vc;
  int                m_bajo, m_alto;

  task automatic model_edge(input logic ps, input logic [DATA_W-1:0] d, input logic en,
                            input logic [N_CH-1:0] p, input logic rq, input logic [DEST_W:0] ix);
    int in_pre, dst;
    bit any_pre, mv;
    in_pre  = m_in.size();
    any_pre = (in_pre != 0);
    for (int k = 0; k < N_CH; k++) if (m_out[k].size() != 0) any_pre = 1'b1;
    mv  = 1'b0;
    dst = 0;
    if (en && in_pre > 0) begin
      dst = int'(m_in[0] >> (DATA_W - DEST_W));
      mv  = (m_out[dst].size() < m_alto);
    end
    if (rq) begin
      m_vc  = 1'b1;
      m_sal = (int'(ix) < N_CH) ? m_deliv[int'(ix)] : m_ovf;
    end else begin
      m_vc = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (p[k] && m_out[k].size() > 0) begin
        m_data[k]  = m_out[k].pop_front();
        m_valid[k] = 1'b1;
        m_deliv[k] = m_deliv[k] + 8'd1;
      end else begin
        m_valid[k] = 1'b0;
      end
    end
    if (mv) m_out[dst].push_back(m_in.pop_front());
    if (ps) begin
      if (in_pre < DEPTH) m_in.push_back(d);
      else begin
        m_err = 1'b1;
        m_ovf = m_ovf + 8'd1;
      end
    end
    m_active = any_pre;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic              push;
    logic [DATA_W-1:0] din;
    logic [N_CH-1:0]   pop;
    logic              req;
    logic [DEST_W:0]   idx;
    logic [N_CH-1:0]   exp_valid;
    logic [DATA_W-1:0] exp_ch2;
    logic              exp_idle;
    logic              exp_vc;
    logic [STAT_W-1:0] exp_sal;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [N_CH-1:0] exp_ae, exp_af;
    int vcount;

    vecs[0] = '{1'b1, 12'h805, 4'b0000, 1'b0, 3'd0, 4'b0000, 12'h000, 1'b1, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 12'h000, 4'b0000, 1'b0, 3'd0, 4'b0000, 12'h000, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{1'b0, 12'h000, 4'b0100, 1'b0, 3'd0, 4'b0100, 12'h805, 1'b0, 1'b0, 8'd0};
    vecs[3] = '{1'b0, 12'h000, 4'b0000, 1'b0, 3'd0, 4'b0000, 12'h805, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{1'b0, 12'h000, 4'b0000, 1'b1, 3'd2, 4'b0000, 12'h805, 1'b1, 1'b1, 8'd1};
    vecs[5] = '{1'b0, 12'h000, 4'b0000, 1'b1, 3'd4, 4'b0000, 12'h805, 1'b1, 1'b1, 8'd0};
    vecs[6] = '{1'b0, 12'h000, 4'b0000, 1'b0, 3'd0, 4'b0000, 12'h805, 1'b1, 1'b0, 8'd0};

    reset = 1'b1; Enable = 1'b1; init = 1'b1;
    umbral_bajo = 4'd1; umbral_alto = 4'd6;
    drive(1'b0, '0, '0, 1'b0, '0);
    #2 reset = 1'b0;
    #1;
    check("reset data_out", data_out, '0);
    check("reset idle", idle, 1'b0);
    check("reset almost_empty", almost_empty, 4'b0000);
    check("reset almost_full", almost_full, 4'b0000);
    tick();
    reset = 1'b1;
    tick(); tick(); tick();      // RESET->INIT, two INIT cycles with init=1
    init = 1'b0;
    tick();
    check("init idle", idle, 1'b1);
    check("init almost_empty", almost_empty, 4'b1111);
    check("init almost_full", almost_full, 4'b0000);
    check("init almost_full_in", almost_full_in, 1'b0);
    check("init valid_out", valid_out, 4'b0000);
    check("init error", error, 1'b0);
    check("init valid_contador", valid_contador, 1'b0);

    // Single word to channel 2 and counter read-back.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].req, vecs[i].idx);
      tick();
      check($sformatf("vec%0d valid_out", i), valid_out, vecs[i].exp_valid);
      check($sformatf("vec%0d ch2", i), ch(2), vecs[i].exp_ch2);
      check($sformatf("vec%0d idle", i), idle, vecs[i].exp_idle);
      check($sformatf("vec%0d valid_contador", i), valid_contador, vecs[i].exp_vc);
      if (vecs[i].exp_vc)
        check($sformatf("vec%0d salida_contador", i), salida_contador, vecs[i].exp_sal);
    end

    // Backpressure on channel 1: stalls at 6, then drains in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 12'h400 | 12'(i), '0, 1'b0, '0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();
    check("bp almost_full", almost_full, 4'b0010);
    check("bp almost_empty", almost_empty, 4'b1101);
    check("bp almost_full_in", almost_full_in, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 4'b0010, 1'b0, '0);
      tick();
      check($sformatf("bp pop%0d valid", i), valid_out, 4'b0010);
      check($sformatf("bp pop%0d data", i), ch(1), 12'h400 | 12'(i));
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();
    check("bp drained idle", idle, 1'b1);

    // Overflow with routing frozen.
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 12'(i), '0, 1'b0, '0);
      tick();
      if (i == 7) begin
        check("ovf almost_full_in at 8", almost_full_in, 1'b1);
        check("ovf no error at 8", error, 1'b0);
      end
      if (i == 8) check("ovf error at 9", error, 1'b1);
    end
    drive(1'b0, '0, '0, 1'b1, 3'd4);
    tick();
    check("ovf read valid", valid_contador, 1'b1);
    check("ovf read value", salida_contador, 8'd2);

    // Asynchronous reset in the middle of traffic.
    Enable = 1'b1;
    drive(1'b0, '0, 4'b0001, 1'b0, '0);
    tick(); tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("mid reset data_out", data_out, '0);
    check("mid reset valid_out", valid_out, 4'b0000);
    check("mid reset almost_full_in", almost_full_in, 1'b0);
    check("mid reset almost_empty", almost_empty, 4'b0000);
    check("mid reset error", error, 1'b0);
    check("mid reset idle", idle, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick();
    reset = 1'b1; init = 1'b1;
    umbral_bajo = 4'd0; umbral_alto = 4'd3;
    tick(); tick();
    init = 1'b0;
    tick();
    check("reinit idle", idle, 1'b1);
    check("reinit almost_empty", almost_empty, 4'b1111);
    check("reinit error", error, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'hC00 | 12'(i), '0, 1'b0, '0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();
    check("new thr almost_full", almost_full, 4'b1000);
    check("new thr almost_empty", almost_empty, 4'b0111);
    check("new thr almost_full_in", almost_full_in, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 4'b1000, 1'b0, '0);
      tick();
      check($sformatf("ch3 pop%0d valid", i), valid_out, 4'b1000);
      check($sformatf("ch3 pop%0d data", i), ch(3), 12'hC00 | 12'(i));
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();

    // Pop on empty channel is ignored.
    drive(1'b0, '0, 4'b0001, 1'b0, '0);
    tick();
    check("empty pop valid", valid_out, 4'b0000);
    drive(1'b0, '0, '0, 1'b1, 3'd3);
    tick();
    check("ch3 count", salida_contador, 8'd5);

    // INIT clears counters; then 256 deliveries wrap channel 3 back to 0.
    drive(1'b0, '0, '0, 1'b0, '0);
    init = 1'b1; tick();
    init = 1'b0; tick();
    drive(1'b0, '0, '0, 1'b1, 3'd3);
    tick();
    check("cleared ch3 count", salida_contador, 8'd0);
    vcount = 0;
    for (int i = 0; i < 262; i++) begin
      drive(i < 256, 12'hC00 | 12'(i & 255), 4'b1000, 1'b0, '0);
      tick();
      if (valid_out[3]) vcount++;
    end
    check("wrap deliveries", vcount, 256);
    drive(1'b0, '0, '0, 1'b1, 3'd3);
    tick();
    check("wrap ch3 count", salida_contador, 8'd0);
    drive(1'b0, '0, '0, 1'b0, '0);
    tick(); tick();

    // Randomized run against the queue model.
    m_bajo = $urandom_range(0, 8);
    m_alto = $urandom_range(1, 8);
    umbral_bajo = CNT_W'(m_bajo);
    umbral_alto = CNT_W'(m_alto);
    init = 1'b1; tick();
    init = 1'b0; tick();
    m_in.delete();
    for (int k = 0; k < N_CH; k++) begin
      m_out[k].delete();
      m_deliv[k] = '0;
      m_data[k]  = '0;
    end
    m_ovf = '0; m_sal = '0; m_valid = '0;
    m_err = 1'b0; m_active = 1'b0; m_vc = 1'b0;
    for (int c = 0; c < 900; c++) begin
      logic              ps, en, rq;
      logic [DATA_W-1:0] d;
      logic [N_CH-1:0]   p;
      logic [DEST_W:0]   ix;
      ps = ($urandom_range(0, 9) < 6);
      d  = DATA_W'($urandom);
      en = ($urandom_range(0, 9) != 0);
      if (c < 300) p = ($urandom_range(0, 3) == 0) ? N_CH'($urandom) : '0;
      else         p = N_CH'($urandom) | N_CH'($urandom);
      rq = ($urandom_range(0, 4) == 0);
      ix = (DEST_W+1)'($urandom);
      drive(ps, d, p, rq, ix);
      Enable = en;
      model_edge(ps, d, en, p, rq, ix);
      tick();
      for (int k = 0; k < N_CH; k++) begin
        exp_ae[k] = (m_out[k].size() <= m_bajo);
        exp_af[k] = (m_out[k].size() >= m_alto);
      end
      check($sformatf("rnd%0d valid_out", c), valid_out, m_valid);
      for (int k = 0; k < N_CH; k++)
        if (m_valid[k]) check($sformatf("rnd%0d data ch%0d", c, k), ch(k), m_data[k]);
      check($sformatf("rnd%0d almost_empty", c), almost_empty, exp_ae);
      check($sformatf("rnd%0d almost_full", c), almost_full, exp_af);
      check($sformatf("rnd%0d almost_full_in", c), almost_full_in, m_in.size() >= m_alto);
      check($sformatf("rnd%0d error", c), error, m_err);
      check($sformatf("rnd%0d idle", c), idle, !m_active);
      check($sformatf("rnd%0d valid_contador", c), valid_contador, m_vc);
      if (m_vc) check($sformatf("rnd%0d salida_contador", c), salida_contador, m_sal);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/capa_transaccion_param.md
# capa_transaccion_param

Parametrised transaction layer: one input FIFO receives DATA_W-bit words, a routing FSM forwards each word to one of N_CH output FIFOs selected by the word's top bits, and downstream pops each output FIFO independently. Programmable almost-empty/almost-full thresholds are latched during INIT. Routing stalls per destination on almost-full backpressure. Per-channel delivered-word counters and an input-overflow counter are read through a req/idx port. It is the generalised successor of the fixed 4-channel, 12-bit transaction layer and sits between the physical-layer receive path and the channel consumers.

## Interface
- DATA_W, 12, word width; destination field is bits [DATA_W-1 -: DEST_W]
- N_CH, 4, output channels, power of two, ≥2; DEST_W = clog2(N_CH)
- DEPTH, 8, entries per FIFO (input and each output), power of two; CNT_W = clog2(DEPTH)+1
- STAT_W, 8, counter width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- FIFO_in  in  DATA_W  input word
- PUSH  in  1  write FIFO_in into input FIFO
- Enable  in  1  1 = routing allowed; 0 = freeze routing (push/pop still work)
- pop  in  N_CH  per-channel pop request
- umbral_bajo  in  CNT_W  almost-empty threshold
- umbral_alto  in  CNT_W  almost-full threshold
- init  in  1  enter/stay in INIT
- req  in  1  counter read request
- idx  in  DEST_W+1  counter select
- data_out  out  N_CH*DATA_W  channel k at [k*DATA_W +: DATA_W], registered
- valid_out  out  N_CH  per-channel data valid, one cycle per popped word
- almost_full_in  out  1  input FIFO count ≥ latched umbral_alto
- almost_empty  out  N_CH  output FIFO count ≤ latched umbral_bajo
- almost_full  out  N_CH  output FIFO count ≥ latched umbral_alto
- error  out  1  sticky: push to full input FIFO
- idle  out  1  FSM in IDLE
- salida_contador  out  STAT_W  counter read data
- valid_contador  out  1  counter read valid

## Operation
- States: RESET, INIT, IDLE, ACTIVE. reset low → RESET asynchronously: all FIFOs empty, counters 0, thresholds 0, every output 0 (almost_empty and idle derive from state/counts after exit).
- RESET → INIT on first edge with reset high.
- INIT: latch umbral_bajo/umbral_alto each cycle; counters cleared; no routing; → IDLE when init=0.
- IDLE: all FIFOs empty; → ACTIVE when any FIFO count ≠ 0; init=1 → INIT.
- ACTIVE: → IDLE when all counts 0; init=1 → INIT (FIFO contents preserved).
- Routing (IDLE or ACTIVE, Enable=1): if input FIFO non-empty and destination d = head[DATA_W-1 -: DEST_W] has almost_full[d]=0, pop head and push into FIFO d in the same edge. Max one word per cycle. Blocked head stalls the whole input FIFO (in-order, head-of-line).
- Input push: accepted iff count < DEPTH at cycle start, regardless of a simultaneous route-pop. Refused push sets error (cleared only by reset) and increments the overflow counter.
- Output pop: pop[k] with count_k ≠ 0 → data_out slice k and valid_out[k]=1 next cycle, and delivered counter k increments. Pop on empty is ignored (valid_out[k]=0, data_out holds).
- Counters wrap modulo 2^STAT_W.
- Counter read: req=1 at edge t → salida_contador valid, valid_contador=1 at t+1 for one cycle. idx < N_CH selects delivered counter idx; idx ≥ N_CH selects the overflow counter. Honoured in all states except RESET. A read coincident with an increment returns the pre-increment value.

## Timing
- Push at edge t → input count updated t; route no earlier than edge t+1; dest count updated at t+1; earliest pop at edge t+2; data_out/valid_out at t+2 (visible after edge t+2). Word-to-output latency is 3 cycles from PUSH assertion.
- Flags are combinational from registered counts and latched thresholds. idle is combinational from state.
- Sustained throughput is 1 word/cycle when destinations are not almost-full.

## Test plan
- Reset low then high, init=1 for 2 cycles with umbral_bajo=1 and umbral_alto=6, then init=0 → idle=1, almost_empty=4'b1111, all other outputs 0.
- Push 0x805 (dest 2), pop[2] two cycles later → data_out ch2=0x805 with valid_out=4'b0100 at cycle 3; idle returns to 1; req with idx=2 → salida_contador=1.
- Push 8 words to dest 1 without popping → ch1 stalls at count 6 (almost_full[1]=1), input FIFO holds 2; one pop[1] releases one word; order is preserved.
- Fill input FIFO (8) with routing blocked (Enable=0), push 2 more → error=1; idx=4 read → 2.
- Pop on empty ch0 → valid_out[0]=0. 256 deliveries on ch3 → counter reads 0 (wrap).
- Assert reset low mid-transfer → all counts 0 and outputs 0 immediately; after release, INIT, then routing resumes with new thresholds.
